// File: rtl/i2c_slave_core.sv
// I2C target-side responder: oversamples SCL/SDA on the core clock, detects
// START/STOP, matches a 7-bit own address, receives write bytes onto a
// parallel output and serialises read bytes from a parallel input, driving
// ACK and data onto the open-drain SDA output.
module i2c_slave_core #(
  parameter int unsigned DATA_SIZE  = 8,
  parameter logic [6:0]  SLAVE_ADDR = 7'h2A
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 reset_ni,
  input  logic                 i2c_scl_i,
  input  logic                 i2c_sda_i,
  output logic                 i2c_sda_o,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_SIZE-1:0] data_from_sda_o,
  output logic                 rx_valid_o,
  output logic                 rw_o,
  output logic                 busy_o
);

  // Shift register must hold at least the 7 address bits ahead of the R/W bit.
  localparam int unsigned SW = (DATA_SIZE > 8) ? DATA_SIZE : 8;
  localparam int unsigned CW = $clog2(SW);
  localparam logic [CW-1:0] ADDR_LAST = CW'(7);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK
  } state_t;

  state_t               state;
  logic                 scl_s1, scl_s2, scl_prev;
  logic                 sda_s1, sda_s2, sda_prev;
  logic [CW-1:0]        cnt;
  logic [SW-2:0]        sh;
  logic [DATA_SIZE-2:0] tx_q;
  // ACK slots span two falls: the first starts the slot, the second ends it.
  // In READ_ACK it records that the master ACKed at the rise.
  logic                 ack_phase;

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  =  scl_s2 & ~scl_prev;
  assign scl_fall  = ~scl_s2 &  scl_prev;
  assign start_det =  scl_s2 & scl_prev &  sda_prev & ~sda_s2;
  assign stop_det  =  scl_s2 & scl_prev & ~sda_prev &  sda_s2;

  // Two-flop synchronisers plus previous-sample registers for edge detection.
  always_ff @(posedge i2c_core_clk_i) begin
    if (!reset_ni) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_prev <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_s1   <= i2c_scl_i;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= i2c_sda_i;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
    end
  end

  // Protocol FSM with registered bus and handshake outputs; STOP beats START
  // beats ordinary SCL bit events.
  always_ff @(posedge i2c_core_clk_i) begin
    if (!reset_ni) begin
      state           <= IDLE;
      i2c_sda_o       <= 1'b1;
      tx_ready_o      <= 1'b0;
      rx_valid_o      <= 1'b0;
      rw_o            <= 1'b0;
      busy_o          <= 1'b0;
      data_from_sda_o <= '0;
      cnt             <= ADDR_LAST;
      sh              <= '0;
      tx_q            <= '1;
      ack_phase       <= 1'b0;
    end else begin
      tx_ready_o <= 1'b0;
      rx_valid_o <= 1'b0;
      if (stop_det) begin
        state     <= IDLE;
        i2c_sda_o <= 1'b1;
        busy_o    <= 1'b0;
        ack_phase <= 1'b0;
      end else if (start_det) begin
        state     <= ADDR;
        cnt       <= ADDR_LAST;
        i2c_sda_o <= 1'b1;
        busy_o    <= 1'b0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            i2c_sda_o <= 1'b1;
          end

          ADDR: begin
            if (scl_rise) begin
              sh <= {sh[SW-3:0], sda_s2};
              if (cnt == '0) begin
                if (sh[6:0] == SLAVE_ADDR) begin
                  rw_o      <= sda_s2;
                  busy_o    <= 1'b1;
                  ack_phase <= 1'b0;
                  state     <= ADDR_ACK;
                end else begin
                  state <= IDLE;
                end
              end else begin
                cnt <= cnt - CW'(1);
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                i2c_sda_o <= 1'b0;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                cnt       <= DATA_LAST;
                if (!rw_o) begin
                  i2c_sda_o <= 1'b1;
                  state     <= WRITE;
                end else begin
                  // No byte ready: send all ones, i.e. leave SDA released.
                  if (tx_valid_i) begin
                    tx_q       <= tx_data_i[DATA_SIZE-2:0];
                    i2c_sda_o  <= tx_data_i[DATA_SIZE-1];
                    tx_ready_o <= 1'b1;
                  end else begin
                    tx_q      <= '1;
                    i2c_sda_o <= 1'b1;
                  end
                  state <= READ;
                end
              end
            end
          end

          WRITE: begin
            if (scl_rise) begin
              sh <= {sh[SW-3:0], sda_s2};
              if (cnt == '0) begin
                data_from_sda_o <= {sh[DATA_SIZE-2:0], sda_s2};
                rx_valid_o      <= 1'b1;
                ack_phase       <= 1'b0;
                state           <= WRITE_ACK;
              end else begin
                cnt <= cnt - CW'(1);
              end
            end
          end

          WRITE_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                i2c_sda_o <= 1'b0;
                ack_phase <= 1'b1;
              end else begin
                i2c_sda_o <= 1'b1;
                ack_phase <= 1'b0;
                cnt       <= DATA_LAST;
                state     <= WRITE;
              end
            end
          end

          READ: begin
            if (scl_fall) begin
              if (cnt == '0) begin
                i2c_sda_o <= 1'b1;
                ack_phase <= 1'b0;
                state     <= READ_ACK;
              end else begin
                i2c_sda_o <= tx_q[DATA_SIZE-2];
                tx_q      <= {tx_q[DATA_SIZE-3:0], 1'b1};
                cnt       <= cnt - CW'(1);
              end
            end
          end

          READ_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                // Master NACK ends the read.
                i2c_sda_o <= 1'b1;
                busy_o    <= 1'b0;
                state     <= IDLE;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              cnt       <= DATA_LAST;
              if (tx_valid_i) begin
                tx_q       <= tx_data_i[DATA_SIZE-2:0];
                i2c_sda_o  <= tx_data_i[DATA_SIZE-1];
                tx_ready_o <= 1'b1;
              end else begin
                tx_q      <= '1;
                i2c_sda_o <= 1'b1;
              end
              state <= READ;
            end
          end

          default: begin
            state     <= IDLE;
            i2c_sda_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: bit-level I2C master on a wired-AND SDA, a
// directed vector table, hand-written corner sequences and randomized
// transactions checked against a transaction-level expectation model.
module tb_i2c_slave_core;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       bus_sda;
  logic       sda_o;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rw;
  logic       busy;

  assign bus_sda = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_slave_core #(.DATA_SIZE(8), .SLAVE_ADDR(7'h2A)) dut (
    .i2c_core_clk_i (clk),
    .reset_ni       (reset_ni),
    .i2c_scl_i      (scl),
    .i2c_sda_i      (bus_sda),
    .i2c_sda_o      (sda_o),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .data_from_sda_o(rx_data),
    .rx_valid_o     (rx_valid),
    .rw_o           (rw),
    .busy_o         (busy)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: running totals of pulses and SDA-low cycles, plus received bytes.
  int         rxv_cnt = 0, txr_cnt = 0, low_cnt = 0, wide_cnt = 0;
  logic       rxv_q = 1'b0;
  logic [7:0] rx_q[$];
  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      rx_q.push_back(rx_data);
    end
    if (rx_valid && rxv_q) wide_cnt++;
    rxv_q = rx_valid;
    if (tx_ready) txr_cnt++;
    if (!sda_o) low_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock: master puts b on SDA in the low phase, returns bus SDA mid-high.
  task automatic clock_bit(input logic b, output logic s);
    wclk(3); sda_m = b; wclk(5);
    scl = 1'b1; wclk(4); s = bus_sda; wclk(4);
    scl = 1'b0;
  endtask

  task automatic start_cond();
    wclk(4); sda_m = 1'b0; wclk(8); scl = 1'b0;
  endtask

  task automatic rep_start();
    wclk(3); sda_m = 1'b1; wclk(5); scl = 1'b1; wclk(8); sda_m = 1'b0; wclk(8); scl = 1'b0;
  endtask

  task automatic stop_cond();
    wclk(3); sda_m = 1'b0; wclk(5); scl = 1'b1; wclk(8); sda_m = 1'b1; wclk(8);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], x);
    clock_bit(1'b1, ack);
  endtask

  task automatic recv8(output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, x);
      b[i] = x;
    end
  endtask

  // Full transaction: START, address, n bytes (master NACKs the last read byte), STOP.
  // Byte k of a read is offered as {v[k], d[k]}; v[n]/d[n] is offered but must not be taken.
  task automatic do_txn(input logic [7:0] addr, input int n,
                        input logic [3:0][7:0] d, input logic [3:0] v,
                        output logic aack, output logic busy_a, output logic rw_a,
                        output logic [3:0] dack, output logic [3:0][7:0] seen,
                        output logic busy_end);
    logic       a, x;
    logic [7:0] b;
    dack = '1; seen = '1;
    tx_valid = v[0]; tx_data = d[0];
    start_cond();
    send_byte(addr, aack);
    busy_a = busy; rw_a = rw;
    for (int k = 0; k < n; k++) begin
      if (!addr[0]) begin
        send_byte(d[k], a);
        dack[k] = a;
      end else begin
        recv8(b);
        seen[k] = b;
        tx_valid = v[k+1]; tx_data = d[k+1];
        clock_bit((k == n - 1), x);
      end
    end
    wclk(4);
    busy_end = busy;
    stop_cond();
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       txv;
    logic       e_aack;
    logic       e_busy;
    logic       e_rw;
    logic       e_dack;
    logic [7:0] e_seen;
    int         e_nrx;
    logic [7:0] e_rxb;
    int         e_ntxr;
    logic       e_quiet;
  } vec_t;

  initial begin
    vec_t            tbl[6];
    logic            aack, busy_a, rw_a, busy_end, a, x;
    logic [3:0]      dack, v;
    logic [3:0][7:0] seen, d;
    logic [7:0]      b, addr;
    int              rx0, tx0, lo0, q0, n, exp_tx;
    logic            match, rd;

    tbl[0] = '{8'h54, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'hA5, 0, 1'b0};
    tbl[1] = '{8'h56, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 0, 1'b1};
    tbl[2] = '{8'h55, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 0, 8'h00, 1, 1'b0};
    tbl[3] = '{8'h55, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 0, 8'h00, 0, 1'b0};
    tbl[4] = '{8'h57, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 0, 8'h00, 0, 1'b1};
    tbl[5] = '{8'h54, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 8'h00, 0, 1'b0};

    tx_valid = 1'b0; tx_data = 8'h00;
    reset_ni = 1'b0;
    wclk(3);
    chk("rst_sda",   32'(sda_o),    32'(1));
    chk("rst_txr",   32'(tx_ready), 32'(0));
    chk("rst_rxv",   32'(rx_valid), 32'(0));
    chk("rst_rw",    32'(rw),       32'(0));
    chk("rst_busy",  32'(busy),     32'(0));
    chk("rst_data",  32'(rx_data),  32'(0));
    reset_ni = 1'b1;
    wclk(4);

    // Directed single-byte vectors
    for (int i = 0; i < 6; i++) begin
      rx0 = rxv_cnt; tx0 = txr_cnt; lo0 = low_cnt; q0 = rx_q.size();
      d = '0; v = '0;
      d[0] = tbl[i].data; v[0] = tbl[i].txv;
      d[1] = 8'h99; v[1] = 1'b1;
      do_txn(tbl[i].addr, 1, d, v, aack, busy_a, rw_a, dack, seen, busy_end);
      chk($sformatf("v%0d_aack", i), 32'(aack),   32'(tbl[i].e_aack));
      chk($sformatf("v%0d_busy", i), 32'(busy_a), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d_rw", i),   32'(rw_a),   32'(tbl[i].e_rw));
      if (!tbl[i].addr[0]) chk($sformatf("v%0d_dack", i), 32'(dack[0]), 32'(tbl[i].e_dack));
      else                 chk($sformatf("v%0d_seen", i), 32'(seen[0]), 32'(tbl[i].e_seen));
      chk($sformatf("v%0d_nrx", i),  32'(rxv_cnt - rx0), 32'(tbl[i].e_nrx));
      if (tbl[i].e_nrx == 1 && rx_q.size() > q0)
        chk($sformatf("v%0d_rxb", i), 32'(rx_q[q0]), 32'(tbl[i].e_rxb));
      chk($sformatf("v%0d_ntxr", i), 32'(txr_cnt - tx0), 32'(tbl[i].e_ntxr));
      chk($sformatf("v%0d_quiet", i), 32'(low_cnt == lo0), 32'(tbl[i].e_quiet));
      chk($sformatf("v%0d_busy_stop", i), 32'(busy), 32'(0));
    end

    // Multi-byte read: 0x81 taken, then nothing valid -> 0xFF, third offer not taken
    tx0 = txr_cnt;
    d = '0; v = '0;
    d[0] = 8'h81; v[0] = 1'b1;
    d[1] = 8'h12; v[1] = 1'b0;
    d[2] = 8'h33; v[2] = 1'b1;
    do_txn(8'h55, 2, d, v, aack, busy_a, rw_a, dack, seen, busy_end);
    chk("mr_aack",  32'(aack),    32'(0));
    chk("mr_b0",    32'(seen[0]), 32'(8'h81));
    chk("mr_b1",    32'(seen[1]), 32'(8'hFF));
    chk("mr_ntxr",  32'(txr_cnt - tx0), 32'(1));
    chk("mr_busy",  32'(busy_end), 32'(0));

    // Repeated START: write 0x11, Sr, read 0x7E, NACK, STOP
    rx0 = rxv_cnt; tx0 = txr_cnt; q0 = rx_q.size();
    tx_valid = 1'b0;
    start_cond();
    send_byte(8'h54, a); chk("rs_aack1", 32'(a), 32'(0));
    send_byte(8'h11, a); chk("rs_dack",  32'(a), 32'(0));
    chk("rs_rw0", 32'(rw), 32'(0));
    tx_valid = 1'b1; tx_data = 8'h7E;
    rep_start();
    send_byte(8'h55, a); chk("rs_aack2", 32'(a), 32'(0));
    chk("rs_rw1",  32'(rw),   32'(1));
    chk("rs_busy", 32'(busy), 32'(1));
    recv8(b); clock_bit(1'b1, x);
    chk("rs_read", 32'(b), 32'(8'h7E));
    stop_cond();
    tx_valid = 1'b0;
    chk("rs_nrx",  32'(rxv_cnt - rx0), 32'(1));
    if (rx_q.size() > q0) chk("rs_rxb", 32'(rx_q[q0]), 32'(8'h11));
    chk("rs_ntxr", 32'(txr_cnt - tx0), 32'(1));

    // STOP after 4 data bits of a write
    rx0 = rxv_cnt;
    start_cond();
    send_byte(8'h54, a); chk("ab_aack", 32'(a), 32'(0));
    clock_bit(1'b1, x); clock_bit(1'b0, x); clock_bit(1'b1, x); clock_bit(1'b1, x);
    stop_cond();
    chk("ab_nrx",  32'(rxv_cnt - rx0), 32'(0));
    chk("ab_busy", 32'(busy),  32'(0));
    chk("ab_sda",  32'(sda_o), 32'(1));

    // Reset while the address ACK is driven
    start_cond();
    for (int i = 7; i >= 0; i--) clock_bit(((8'h54 >> i) & 8'h01) != 0, x);
    wclk(5);
    chk("ra_ackdrv", 32'(sda_o), 32'(0));
    chk("ra_busy1",  32'(busy),  32'(1));
    reset_ni = 1'b0;
    @(posedge clk); #1;
    chk("ra_sda",   32'(sda_o),    32'(1));
    chk("ra_busy",  32'(busy),     32'(0));
    chk("ra_rw",    32'(rw),       32'(0));
    chk("ra_txr",   32'(tx_ready), 32'(0));
    chk("ra_rxv",   32'(rx_valid), 32'(0));
    chk("ra_data",  32'(rx_data),  32'(0));
    @(negedge clk); reset_ni = 1'b1;
    clock_bit(1'b1, x);
    chk("ra_noack", 32'(x), 32'(1));
    stop_cond();

    // Randomized transactions against the expectation model
    for (int t = 0; t < 24; t++) begin
      match = 1'($urandom_range(0, 1));
      rd    = 1'($urandom_range(0, 1));
      addr[0] = rd;
      if (match) addr[7:1] = 7'h2A;
      else begin
        addr[7:1] = 7'($urandom);
        while (addr[7:1] == 7'h2A) addr[7:1] = 7'($urandom);
      end
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) begin
        d[k] = 8'($urandom);
        v[k] = 1'($urandom_range(0, 1));
      end
      rx0 = rxv_cnt; tx0 = txr_cnt; q0 = rx_q.size();
      do_txn(addr, n, d, v, aack, busy_a, rw_a, dack, seen, busy_end);
      exp_tx = 0;
      for (int k = 0; k < n; k++) if (match && rd && v[k]) exp_tx++;
      chk($sformatf("r%0d_aack", t), 32'(aack),   32'(!match));
      chk($sformatf("r%0d_busy", t), 32'(busy_a), 32'(match));
      if (match) chk($sformatf("r%0d_rw", t), 32'(rw_a), 32'(rd));
      for (int k = 0; k < n; k++) begin
        if (!rd) chk($sformatf("r%0d_dack%0d", t, k), 32'(dack[k]), 32'(!match));
        else     chk($sformatf("r%0d_seen%0d", t, k), 32'(seen[k]),
                     32'((match && v[k]) ? d[k] : 8'hFF));
      end
      chk($sformatf("r%0d_nrx", t), 32'(rxv_cnt - rx0), 32'((match && !rd) ? n : 0));
      if (match && !rd)
        for (int k = 0; k < n; k++)
          if (rx_q.size() > q0 + k) chk($sformatf("r%0d_rxb%0d", t, k), 32'(rx_q[q0+k]), 32'(d[k]));
      chk($sformatf("r%0d_ntxr", t), 32'(txr_cnt - tx0), 32'(exp_tx));
      chk($sformatf("r%0d_bend", t), 32'(busy_end), 32'(match && !rd));
      chk($sformatf("r%0d_bstop", t), 32'(busy), 32'(0));
    end

    chk("rxv_width", 32'(wide_cnt), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_core.md
# i2c_slave_core

Target-side (slave) I2C responder running on the I2C core clock. It oversamples the bus SCL/SDA, detects START and STOP, and matches a 7-bit own address. On write transfers it receives bytes into a parallel output with a valid strobe. On read transfers it serialises bytes from a parallel input, and it drives ACK/NACK and data onto the open-drain SDA output. It is the bus-side counterpart to the master datapath and FSM.

## Interface
- `DATA_SIZE`, default 8: byte width; the MSB is shifted first.
- `SLAVE_ADDR`, default 7'h2A: own 7-bit address.
- `i2c_core_clk_i`  in  1: core clock; all logic is on its rising edge.
- `reset_ni`  in  1: reset, synchronous, active-low.
- `i2c_scl_i`  in  1: bus SCL, asynchronous.
- `i2c_sda_i`  in  1: bus SDA, asynchronous.
- `i2c_sda_o`  out  1: 0 drives SDA low; 1 releases it (open-drain).
- `tx_data_i`  in  DATA_SIZE: byte to return on a read.
- `tx_valid_i`  in  1: `tx_data_i` holds a byte ready to send.
- `tx_ready_o`  out  1: one-cycle pulse when a byte is taken from `tx_data_i`.
- `data_from_sda_o`  out  DATA_SIZE: last byte received on a write.
- `rx_valid_o`  out  1: one-cycle pulse when `data_from_sda_o` updates.
- `rw_o`  out  1: R/W bit of the current matched transfer (1 = read).
- `busy_o`  out  1: high from an address match until STOP, NACK-end, or reset.

## Operation
- SCL and SDA each pass through a 2-flop synchroniser, then a previous-sample register.
  - `scl_rise`/`scl_fall`: synchronised SCL differs from the previous sample.
  - START: synchronised SDA falls while SCL is high.
  - STOP: synchronised SDA rises while SCL is high.
- Data bits are sampled on `scl_rise`. `i2c_sda_o` changes only on `scl_fall`.
- A bit counter runs DATA_SIZE-1 down to 0 and reloads at START and at each ACK slot.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
- IDLE: SDA released; waits for START, then goes to ADDR.
- ADDR: shifts 8 bits.
  - After the 8th rise, if bits[7:1] == SLAVE_ADDR: latch `rw_o`, set `busy_o`, and drive SDA low at the next fall (ADDR_ACK).
  - On mismatch: go to IDLE with SDA never driven.
- ADDR_ACK: holds SDA low through the ACK clock. At the following fall:
  - rw=0: release SDA and go to WRITE.
  - rw=1: load the byte, drive its MSB, and go to READ.
- WRITE: shifts 8 bits.
  - After the 8th rise, `data_from_sda_o` updates and `rx_valid_o` pulses.
  - At the next fall, drive ACK (WRITE_ACK).
  - At the fall after the ACK clock, release SDA and return to WRITE.
- READ: drives the next bit at each fall. After the 8th bit's clock, release SDA at the fall and go to READ_ACK.
- READ_ACK: samples the master's bit at the rise.
  - 0 (ACK): at the next fall, load the next byte and drive its MSB (READ).
  - 1 (NACK): release SDA, clear `busy_o`, go to IDLE.
- Byte load:
  - `tx_valid_i`=1: take `tx_data_i` and pulse `tx_ready_o` in the same cycle.
  - `tx_valid_i`=0: send 0xFF (SDA released) and do not pulse `tx_ready_o`.
  - No clock stretching.
- Priority within one cycle: STOP > START > bit events.
  - STOP in any state: IDLE, release SDA, clear `busy_o`, no `rx_valid_o` for a partial byte.
  - START (including repeated) in any state: ADDR, release SDA, clear `busy_o`, discard the partial byte.

## Timing
- Reset (`reset_ni`=0 at a clock edge) forces:
  - state IDLE, `i2c_sda_o`=1;
  - `tx_ready_o`, `rx_valid_o`, `rw_o`, `busy_o` = 0;
  - `data_from_sda_o`=0; synchroniser flops = 1.
- Reset mid-transfer releases SDA at that same edge. After release, only the next START is acted on.
- Pin to event: an SCL/SDA pin edge is recognised 3 core clocks later (2 synchroniser + 1 edge detect).
- `i2c_sda_o` updates 1 clock after `scl_fall` is recognised.
- `rx_valid_o` pulses 1 clock after the 8th `scl_rise` is recognised, and is exactly 1 cycle wide.
- Environment requirements:
  - core clock ≥ 8× SCL;
  - the master changes SDA ≥ 1 core clock after SCL falls;
  - SCL high and low each last ≥ 4 core clocks.

## Test plan
- Write: START, 0x54, 0xA5, STOP → ACK low on both ACK clocks; `data_from_sda_o`=0xA5; one `rx_valid_o` pulse; `busy_o` 1 then 0 after STOP.
- Mismatch: START, 0x56, 0x11 → `i2c_sda_o` stays 1 throughout; no `rx_valid_o`; `busy_o` stays 0.
- Read: START, 0x55, `tx_data_i`=0x3C with `tx_valid_i`=1, master NACK → SDA bits 0,0,1,1,1,1,0,0; one `tx_ready_o` pulse; SDA released; IDLE; `rw_o`=1.
- Multi-byte read: 0x55, first byte 0x81 then master ACK, `tx_valid_i`=0, then NACK → second byte 0xFF; exactly one `tx_ready_o` pulse.
- Repeated START: 0x54, 0x11, Sr, 0x55, read 0x7E, NACK, STOP → `rx_valid_o` with 0x11; 0x7E transmitted; `rw_o` 0 then 1.
- Aborts:
  - STOP after 4 data bits of a write → no `rx_valid_o`; IDLE.
  - `reset_ni`=0 while driving ACK → `i2c_sda_o`=1 on that edge; all outputs at reset values.
